// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
//
// Steps external analog-mux address lines through a frame of slots:
//   slot 0                : service slot, selector code taken from a small
//                           rotating, runtime-writable table
//   slots 1..FRAME_LEN-2  : data slots, bank/channel derived from slot index
//   slot FRAME_LEN-1      : park slot (PARK_SEL, channel 0)
// Each step is followed by a settle interval, then a one-cycle sample strobe.
// Steps come from an external switch level (mode=0) or an auto-timer (mode=1).
//
// Ports
//   clk, reset (async, active-low), sync_clr (sync clear, table preserved)
//   enable, mode, switch_sig         : step control
//   svc_we, svc_waddr, svc_wdata     : service table write port
//   chan_addr, bank_sel              : registered mux address outputs
//   slot, svc_ptr                    : current slot, next service table index
//   frame_start, sample_strobe       : one-cycle pulses
//   busy, state                      : FSM status (IDLE=0, SETTLE=1, READY=2)
// ---------------------------------------------------------------------------
module mux_scan_sequencer #(
    parameter int ADDR_W    = 3,
    parameter int N_BANKS   = 2,
    parameter int SEL_W     = 3,
    parameter int SVC_DEPTH = 4,
    parameter int PARK_SEL  = 4,
    parameter int SETTLE    = 4,
    parameter int DWELL     = 8,
    localparam int FRAME_LEN = N_BANKS * (2 ** ADDR_W) + 2,
    localparam int SLOT_W    = $clog2(FRAME_LEN),
    localparam int PTR_W     = $clog2(SVC_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_clr,
    input  logic              enable,
    input  logic              mode,
    input  logic              switch_sig,
    input  logic              svc_we,
    input  logic [PTR_W-1:0]  svc_waddr,
    input  logic [SEL_W-1:0]  svc_wdata,
    output logic [ADDR_W-1:0] chan_addr,
    output logic [SEL_W-1:0]  bank_sel,
    output logic [SLOT_W-1:0] slot,
    output logic [PTR_W-1:0]  svc_ptr,
    output logic              frame_start,
    output logic              sample_strobe,
    output logic              busy,
    output logic [1:0]        state
);

    localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  DWELL_END  = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  PARK_CODE  = SEL_W'(PARK_SEL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              strobe_next;
    logic              step;
    logic              mode_reg;      // mode latched for the duration of a step

    logic [SLOT_W-1:0] slot_next;
    logic [SLOT_W-1:0] data_idx;
    logic [SEL_W-1:0]  bank_next;
    logic [ADDR_W-1:0] chan_next;
    logic              to_service;

    // ------------------------------------------------------------------
    // Service table: one register per entry, reset to the park code.
    // sync_clr deliberately does not touch it.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]     svc_table [SVC_DEPTH];
    logic [SVC_DEPTH-1:0] entry_we;

    genvar gi;
    generate
        for (gi = 0; gi < SVC_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = svc_we && (svc_waddr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SVC_DEPTH; i++) begin
                svc_table[i] <= PARK_CODE;
            end
        end else begin
            for (int i = 0; i < SVC_DEPTH; i++) begin
                if (entry_we[i]) begin
                    svc_table[i] <= svc_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else if (sync_clr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. One shared counter times both the settle and
    // the dwell interval, since the two never overlap.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        strobe_next = 1'b0;
        step        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable && (mode || switch_sig)) begin
                    step       = 1'b1;
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == SETTLE_END) begin
                    state_next  = ST_READY;
                    cnt_next    = '0;
                    strobe_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_READY: begin
                if (mode_reg) begin
                    if (cnt_reg == DWELL_END) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else if (!switch_sig) begin
                    // External mode waits for the level to drop, so a held
                    // switch produces exactly one step.
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot mapping for the slot about to be entered
    // ------------------------------------------------------------------
    always_comb begin
        slot_next  = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
        data_idx   = slot_next - SLOT_W'(1);
        to_service = (slot_next == '0);
        bank_next  = PARK_CODE;
        chan_next  = '0;
        if (to_service) begin
            // Read uses the pre-edge table contents, so a same-edge write
            // to this entry only shows up the next time it is visited.
            bank_next = svc_table[svc_ptr];
        end else if (slot_next != LAST_SLOT) begin
            bank_next = SEL_W'(data_idx >> ADDR_W);
            chan_next = data_idx[ADDR_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Counters, pulses and registered mux outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg       <= '0;
            mode_reg      <= 1'b0;
            slot          <= LAST_SLOT;
            chan_addr     <= '0;
            bank_sel      <= PARK_CODE;
            svc_ptr       <= '0;
            frame_start   <= 1'b0;
            sample_strobe <= 1'b0;
        end else if (sync_clr) begin
            cnt_reg       <= '0;
            mode_reg      <= 1'b0;
            slot          <= LAST_SLOT;
            chan_addr     <= '0;
            bank_sel      <= PARK_CODE;
            svc_ptr       <= '0;
            frame_start   <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            sample_strobe <= strobe_next;
            frame_start   <= 1'b0;
            if (step) begin
                mode_reg    <= mode;
                slot        <= slot_next;
                chan_addr   <= chan_next;
                bank_sel    <= bank_next;
                frame_start <= to_service;
                if (to_service) begin
                    // Table depth is a power of two, so the wrap is free.
                    svc_ptr <= svc_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign busy  = (state_reg != ST_IDLE);
    assign state = state_reg;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
//
// Self-checking bench for mux_scan_sequencer with default parameters.
// A behavioural frame model pushes the expected (slot, bank_sel, chan_addr)
// of every step onto a queue when stimulus is applied; the scoreboard pops
// and compares as the DUT steps and strobes.
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;

    localparam int ADDR_W    = 3;
    localparam int SEL_W     = 3;
    localparam int SVC_DEPTH = 4;
    localparam int PARK_SEL  = 4;
    localparam int SETTLE    = 4;
    localparam int DWELL     = 8;
    localparam int FRAME_LEN = 18;
    localparam int SLOT_W    = 5;
    localparam int PTR_W     = 2;
    localparam int PERIOD    = SETTLE + DWELL + 1;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [SEL_W-1:0]  bank;
        logic [ADDR_W-1:0] chan;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              sync_clr;
    logic              enable;
    logic              mode;
    logic              switch_sig;
    logic              svc_we;
    logic [PTR_W-1:0]  svc_waddr;
    logic [SEL_W-1:0]  svc_wdata;
    logic [ADDR_W-1:0] chan_addr;
    logic [SEL_W-1:0]  bank_sel;
    logic [SLOT_W-1:0] slot;
    logic [PTR_W-1:0]  svc_ptr;
    logic              frame_start;
    logic              sample_strobe;
    logic              busy;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    int   svc_seen[$];
    int   ptr_seen[$];

    int m_slot;
    int m_ptr;
    int m_table[SVC_DEPTH];

    mux_scan_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .sync_clr      (sync_clr),
        .enable        (enable),
        .mode          (mode),
        .switch_sig    (switch_sig),
        .svc_we        (svc_we),
        .svc_waddr     (svc_waddr),
        .svc_wdata     (svc_wdata),
        .chan_addr     (chan_addr),
        .bank_sel      (bank_sel),
        .slot          (slot),
        .svc_ptr       (svc_ptr),
        .frame_start   (frame_start),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Frame model: advance one step and queue its expected mapping.
    task automatic model_push(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            m_slot = (m_slot == FRAME_LEN - 1) ? 0 : m_slot + 1;
            e.slot = SLOT_W'(m_slot);
            if (m_slot == 0) begin
                e.bank = SEL_W'(m_table[m_ptr]);
                e.chan = '0;
                m_ptr  = (m_ptr + 1) % SVC_DEPTH;
            end else if (m_slot == FRAME_LEN - 1) begin
                e.bank = SEL_W'(PARK_SEL);
                e.chan = '0;
            end else begin
                e.bank = SEL_W'((m_slot - 1) / 8);
                e.chan = ADDR_W'((m_slot - 1) % 8);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        sync_clr   = 1'b0;
        enable     = 1'b0;
        mode       = 1'b1;
        switch_sig = 1'b0;
        svc_we     = 1'b0;
        svc_waddr  = '0;
        svc_wdata  = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        m_slot = FRAME_LEN - 1;
        m_ptr  = 0;
        for (int i = 0; i < SVC_DEPTH; i++) m_table[i] = PARK_SEL;
        exp_q.delete();
    endtask

    task automatic write_table(input int a, input int d);
        @(negedge clk);
        svc_we    = 1'b1;
        svc_waddr = PTR_W'(a);
        svc_wdata = SEL_W'(d);
        @(negedge clk);
        svc_we     = 1'b0;
        m_table[a] = d;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (state !== 2'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL %s_idle: state=%0d required 0 within 40 cycles", name, state);
        end
    endtask

    // Scoreboard: detect each step (entry into SETTLE), check the mapping
    // on the cycle after the step edge, check strobe latency and period,
    // then pop and compare again on the strobe.
    task automatic score_steps(input int n_steps, input int limit, input bit auto_period,
                               input string name);
        int   cyc = 0;
        int   got = 0;
        int   step_cyc = -1000;
        int   last_strobe = -1;
        logic [1:0] prev = state;
        exp_t e;
        while (got < n_steps && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (state == 2'd1 && prev != 2'd1) begin
                step_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_unexpected_step: slot=%0d with empty scoreboard", name, slot);
                end else begin
                    e = exp_q[0];
                    if ({slot, bank_sel, chan_addr, frame_start} !== {e.slot, e.bank, e.chan, (e.slot == 0)}) begin
                        errors++;
                        $display("FAIL %s_step_outputs: slot=%0d bank=%0d chan=%0d fs=%0d required slot=%0d bank=%0d chan=%0d fs=%0d",
                                 name, slot, bank_sel, chan_addr, frame_start, e.slot, e.bank, e.chan, (e.slot == 0));
                    end
                    if (e.slot == 0) ptr_seen.push_back(int'(svc_ptr));
                end
            end
            if (sample_strobe) begin
                // Step edge plus SETTLE further edges: SETTLE+1 edges in all.
                checks++;
                if (cyc - step_cyc != SETTLE) begin
                    errors++;
                    $display("FAIL %s_strobe_latency: %0d cycles after step sample, required %0d",
                             name, cyc - step_cyc, SETTLE);
                end
                if (auto_period && last_strobe >= 0) begin
                    checks++;
                    if (cyc - last_strobe != PERIOD) begin
                        errors++;
                        $display("FAIL %s_strobe_period: %0d required %0d", name, cyc - last_strobe, PERIOD);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_unexpected_strobe: slot=%0d with empty scoreboard", name, slot);
                end else begin
                    e = exp_q.pop_front();
                    $display("step: slot=%0d bank_sel=%0d chan_addr=%0d svc_ptr=%0d", slot, bank_sel, chan_addr, svc_ptr);
                    if ({slot, bank_sel, chan_addr} !== {e.slot, e.bank, e.chan}) begin
                        errors++;
                        $display("FAIL %s_strobe_outputs: slot=%0d bank=%0d chan=%0d required slot=%0d bank=%0d chan=%0d",
                                 name, slot, bank_sel, chan_addr, e.slot, e.bank, e.chan);
                    end
                    if (e.slot == 0) svc_seen.push_back(int'(bank_sel));
                end
                got++;
                last_strobe = cyc;
            end
            prev = state;
        end
        checks++;
        if (got != n_steps) begin
            errors++;
            $display("FAIL %s_step_count: %0d strobes seen, required %0d", name, got, n_steps);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({state, busy, slot, bank_sel, chan_addr, svc_ptr, frame_start, sample_strobe} !==
            {2'd0, 1'b0, SLOT_W'(FRAME_LEN - 1), SEL_W'(PARK_SEL), ADDR_W'(0), PTR_W'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: state=%0d busy=%0d slot=%0d bank=%0d chan=%0d ptr=%0d fs=%0d ss=%0d required 0 0 17 4 0 0 0 0",
                     state, busy, slot, bank_sel, chan_addr, svc_ptr, frame_start, sample_strobe);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 2'd0 || slot !== SLOT_W'(FRAME_LEN - 1)) begin
            errors++;
            $display("FAIL reset_no_step_disabled: state=%0d slot=%0d required 0 17", state, slot);
        end
    endtask

    task automatic test_auto_frame();
        do_reset();
        enable = 1'b1;
        model_push(FRAME_LEN);
        score_steps(FRAME_LEN, FRAME_LEN * PERIOD + 30, 1'b1, "auto_frame");
        enable = 1'b0;
        wait_idle("auto_frame");
    endtask

    task automatic test_svc_table();
        int exp_svc[5] = '{3, 5, 2, 5, 3};
        do_reset();
        write_table(0, 3);
        write_table(1, 5);
        write_table(2, 2);
        write_table(3, 5);
        svc_seen.delete();
        ptr_seen.delete();
        enable = 1'b1;
        model_push(5 * FRAME_LEN);
        score_steps(5 * FRAME_LEN, 5 * FRAME_LEN * PERIOD + 30, 1'b1, "svc_table");
        enable = 1'b0;
        wait_idle("svc_table");
        checks++;
        if (svc_seen.size() != 5) begin
            errors++;
            $display("FAIL svc_table_count: %0d service slots, required 5", svc_seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (svc_seen[i] != exp_svc[i]) begin
                    errors++;
                    $display("FAIL svc_table_seq[%0d]: bank_sel=%0d required %0d", i, svc_seen[i], exp_svc[i]);
                end
            end
        end
        checks++;
        if (ptr_seen.size() < 4 || ptr_seen[2] != 3 || ptr_seen[3] != 0) begin
            errors++;
            $display("FAIL svc_ptr_wrap: entries=%0d ptr[2]=%0d ptr[3]=%0d required 3 then 0",
                     ptr_seen.size(), (ptr_seen.size() > 2) ? ptr_seen[2] : -1,
                     (ptr_seen.size() > 3) ? ptr_seen[3] : -1);
        end
    endtask

    task automatic test_ext_hold();
        int bad = 0;
        do_reset();
        mode   = 1'b0;
        enable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (state !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ext_no_step_low: %0d busy cycles with switch_sig low, required 0", bad);
        end
        model_push(1);
        switch_sig = 1'b1;
        score_steps(1, 20, 1'b0, "ext_hold");
        bad = 0;
        repeat (33) begin
            @(negedge clk);
            if (state !== 2'd2 || sample_strobe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ext_hold_ready: %0d cycles left READY or strobed while held, required 0", bad);
        end
        switch_sig = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ext_release_idle: state=%0d busy=%0d required 0 0", state, busy);
        end
        // A short pulse that falls during SETTLE still completes the step,
        // and READY leaves at once because the level is already low.
        model_push(1);
        switch_sig = 1'b1;
        fork
            score_steps(1, 20, 1'b0, "ext_pulse");
            begin
                repeat (2) @(negedge clk);
                switch_sig = 1'b0;
            end
        join
        @(negedge clk);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL ext_pulse_idle: state=%0d required 0", state);
        end
    endtask

    task automatic test_enable_drop();
        int steps = 0;
        logic [1:0] prev;
        do_reset();
        model_push(1);
        enable = 1'b1;
        fork
            score_steps(1, 25, 1'b0, "enable_drop");
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (state == 2'd1) break;
                end
                enable = 1'b0;
            end
        join
        prev = state;
        repeat (40) begin
            @(negedge clk);
            if ((state == 2'd1 && prev != 2'd1) || sample_strobe) steps++;
            prev = state;
        end
        checks++;
        if (steps != 0) begin
            errors++;
            $display("FAIL enable_drop_hold: %0d steps while disabled, required 0", steps);
        end
        model_push(1);
        enable = 1'b1;
        score_steps(1, 25, 1'b0, "enable_return");
        enable = 1'b0;
        wait_idle("enable_return");
    endtask

    task automatic test_sync_clr();
        do_reset();
        write_table(0, 6);
        write_table(1, 1);
        model_push(1);
        enable = 1'b1;
        score_steps(1, 25, 1'b1, "sync_clr_pre");
        sync_clr = 1'b1;
        enable   = 1'b0;
        @(negedge clk);
        sync_clr = 1'b0;
        checks++;
        if ({state, slot, bank_sel, chan_addr, svc_ptr, sample_strobe, frame_start} !==
            {2'd0, SLOT_W'(FRAME_LEN - 1), SEL_W'(PARK_SEL), ADDR_W'(0), PTR_W'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sync_clr_values: state=%0d slot=%0d bank=%0d chan=%0d ptr=%0d ss=%0d fs=%0d required 0 17 4 0 0 0 0",
                     state, slot, bank_sel, chan_addr, svc_ptr, sample_strobe, frame_start);
        end
        m_slot = FRAME_LEN - 1;
        m_ptr  = 0;
        svc_seen.delete();
        model_push(2);
        enable = 1'b1;
        score_steps(2, 2 * PERIOD + 20, 1'b1, "sync_clr_post");
        enable = 1'b0;
        wait_idle("sync_clr_post");
        checks++;
        if (svc_seen.size() < 1 || svc_seen[0] != 6) begin
            errors++;
            $display("FAIL sync_clr_table_kept: service bank_sel=%0d required 6",
                     (svc_seen.size() > 0) ? svc_seen[0] : -1);
        end
    endtask

    task automatic test_same_edge_write();
        int exp_svc[5] = '{4, 4, 4, 4, 6};
        int n_steps = 4 * FRAME_LEN + 1;
        do_reset();
        svc_seen.delete();
        // Step to slot 0 reads entry 0 on the same edge it is written.
        model_push(1);
        m_table[0] = 6;
        model_push(n_steps - 1);
        enable    = 1'b1;
        svc_we    = 1'b1;
        svc_waddr = '0;
        svc_wdata = SEL_W'(6);
        fork
            score_steps(n_steps, n_steps * PERIOD + 30, 1'b1, "same_edge");
            begin
                @(negedge clk);
                svc_we = 1'b0;
            end
        join
        enable = 1'b0;
        wait_idle("same_edge");
        checks++;
        if (svc_seen.size() != 5) begin
            errors++;
            $display("FAIL same_edge_count: %0d service slots, required 5", svc_seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (svc_seen[i] != exp_svc[i]) begin
                    errors++;
                    $display("FAIL same_edge_seq[%0d]: bank_sel=%0d required %0d", i, svc_seen[i], exp_svc[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_frame();
        test_svc_table();
        test_ext_hold();
        test_enable_drop();
        test_sync_clr();
        test_same_edge_write();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
